// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally and skip the iterative phase.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] inputA,
    input  logic [XLEN-1:0] inputB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_reg, state_next;
    logic [2:0]      op_reg;
    logic [4:0]      count_reg;
    logic [XLEN-1:0] a_reg, hi_reg, lo_reg, result_reg;
    logic            neg_q_reg, neg_r_reg, busy_reg, done_reg;

    logic            a_signed, b_signed, sign_a, sign_b, is_div, div_zero, div_ovf, skip_calc;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub, quot, rem, fix_result;
    logic [2*XLEN-1:0] product, prod_fix;

    // Operand decode at the start of an operation.
    always_comb begin
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sign_a   = a_signed & inputA[XLEN-1];
        sign_b   = b_signed & inputB[XLEN-1];
        mag_a    = sign_a ? -inputA : inputA;
        mag_b    = sign_b ? -inputB : inputB;
        is_div   = op[2];
        div_zero = is_div && (inputB == '0);
        div_ovf  = is_div && !op[0] && (inputA == MIN_NEG) && (inputB == '1);
`ifdef MULDIV_FAST_MUL_EN
        skip_calc = div_zero || div_ovf || !is_div;
`else
        skip_calc = div_zero || div_ovf;
`endif
    end

    // One iteration step; a_reg holds the multiplicand or the divisor magnitude.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_ge    = div_shift >= {1'b0, a_reg};
        div_sub   = div_shift[XLEN-1:0] - a_reg;
    end

    // Sign correction and hi/lo select; special cases arrive here pre-loaded with neg flags clear.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        product = op_reg[2] ? {hi_reg, lo_reg}
                            : {{XLEN{1'b0}}, a_reg} * {{XLEN{1'b0}}, lo_reg};
`else
        product = {hi_reg, lo_reg};
`endif
        prod_fix = neg_q_reg ? -product : product;
        quot     = neg_q_reg ? -lo_reg : lo_reg;
        rem      = neg_r_reg ? -hi_reg : hi_reg;
        if (op_reg[2])
            fix_result = op_reg[1] ? rem : quot;
        else if (op_reg[1:0] == 2'd0)
            fix_result = prod_fix[XLEN-1:0];
        else
            fix_result = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!nRst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = skip_calc ? FIX : CALC;
            CALC: if (count_reg == 5'(XLEN-1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            op_reg    <= '0;
            count_reg <= '0;
            a_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    op_reg    <= op;
                    count_reg <= '0;
                    if (div_zero) begin
                        hi_reg    <= inputA;
                        lo_reg    <= '1;
                        neg_q_reg <= 1'b0;
                        neg_r_reg <= 1'b0;
                    end else if (div_ovf) begin
                        hi_reg    <= '0;
                        lo_reg    <= MIN_NEG;
                        neg_q_reg <= 1'b0;
                        neg_r_reg <= 1'b0;
                    end else if (!is_div) begin
                        a_reg     <= mag_a;
                        hi_reg    <= '0;
                        lo_reg    <= mag_b;
                        neg_q_reg <= sign_a ^ sign_b;
                        neg_r_reg <= 1'b0;
                    end else begin
                        a_reg     <= mag_b;
                        hi_reg    <= '0;
                        lo_reg    <= mag_a;
                        neg_q_reg <= sign_a ^ sign_b;
                        neg_r_reg <= sign_a;
                    end
                end
                CALC: begin
                    count_reg <= count_reg + 5'd1;
                    if (!op_reg[2]) begin
                        hi_reg <= mul_sum[XLEN:1];
                        lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
                    end else begin
                        hi_reg <= div_ge ? div_sub : div_shift[XLEN-1:0];
                        lo_reg <= {lo_reg[XLEN-2:0], div_ge};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= (state_next == DONE);
            if (state_reg == FIX && state_next == DONE)
                result_reg <= fix_result;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
endmodule
